// File: rtl/ray_intake_queue.sv
// rtl/ray_intake_queue.sv - ray intake FIFO with raster pixel tagging and registered head (option: RAY_INTAKE_STATS_EN)
module ray_intake_queue #(
    parameter int WIDTH        = 16,
    parameter int PIXEL_WIDTH  = 10,
    parameter int PIXEL_HEIGHT = 9,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int DEPTH        = 16,
    parameter int AF_MARGIN    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [6*WIDTH-1:0]        ray_in,
    input  logic                      valid_in,
    output logic [6*WIDTH-1:0]        ray_out,
    output logic [PIXEL_WIDTH-1:0]    pixel_x,
    output logic [PIXEL_HEIGHT-1:0]   pixel_y,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic                      almost_full,
    output logic                      overflow,
    output logic                      frame_done,
    output logic [$clog2(DEPTH):0]    count
`ifdef RAY_INTAKE_STATS_EN
    ,
    output logic [31:0]               drop_count,
    output logic [$clog2(DEPTH):0]    max_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 6*WIDTH + PIXEL_WIDTH + PIXEL_HEIGHT;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(DEPTH - AF_MARGIN);

    logic [EW-1:0]           mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr, rd_ptr_next;
    logic [PIXEL_WIDTH-1:0]  wx;
    logic [PIXEL_HEIGHT-1:0] wy;
    logic                    full, push, pop, drop, last_x, last_pix;
    logic [AW:0]             count_next;
    logic [EW-1:0]           wr_entry, head_next;

    assign full        = (count == FULL_CNT);
    assign pop         = valid_out && ready_in;
    assign push        = valid_in && (!full || pop);
    assign drop        = valid_in && full && !pop;
    assign last_x      = (wx == PIXEL_WIDTH'(H_RES - 1));
    assign last_pix    = last_x && (wy == PIXEL_HEIGHT'(V_RES - 1));
    assign wr_entry    = {ray_in, wx, wy};
    assign rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;

    // The incoming entry must bypass the array when it becomes the new head this cycle.
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
        head_next = (push && (wr_ptr == rd_ptr_next)) ? wr_entry : mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wx          <= '0;
            wy          <= '0;
            valid_out   <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            frame_done  <= 1'b0;
            ray_out     <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wx          <= '0;
            wy          <= '0;
            valid_out   <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            frame_done  <= 1'b0;
            ray_out     <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            // Tags advance even for dropped rays so they stay raster-aligned.
            if (valid_in) begin
                wx <= last_x ? '0 : wx + 1'b1;
                if (last_x)
                    wy <= (wy == PIXEL_HEIGHT'(V_RES - 1)) ? '0 : wy + 1'b1;
            end
            frame_done  <= valid_in && last_pix;
            overflow    <= overflow || drop;
            almost_full <= (count_next >= AF_CNT);
            valid_out   <= (count_next != '0);
            if (count_next != '0)
                {ray_out, pixel_x, pixel_y} <= head_next;
        end
    end

`ifdef RAY_INTAKE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
            max_count  <= '0;
        end else if (clear) begin
            drop_count <= '0;
            max_count  <= '0;
        end else begin
            if (drop && (drop_count != '1))
                drop_count <= drop_count + 1'b1;
            if (count_next > max_count)
                max_count <= count_next;
        end
    end
`endif

endmodule
